// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode type and encodings.
package usr_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_LOAD = 3'b001;
  localparam mode_t MODE_SHL  = 3'b010;
  localparam mode_t MODE_SHR  = 3'b011;
  localparam mode_t MODE_ROL  = 3'b100;
  localparam mode_t MODE_ROR  = 3'b101;
  localparam mode_t MODE_INC  = 3'b110;
  localparam mode_t MODE_DEC  = 3'b111;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle for univ_shift_reg. The master drives the operation,
// the slave (the register) returns contents and flags.
interface univ_shift_reg_if #(parameter int WIDTH = 8);
  import usr_pkg::*;

  logic             en;
  mode_t            mode;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             carry;
  logic             zero;

  modport master (output en, mode, d, sin_l, sin_r,
                  input  q, sout, carry, zero);
  modport slave  (input  en, mode, d, sin_l, sin_r,
                  output q, sout, carry, zero);
endinterface

// File: rtl/usr_next_state.sv
// Combinational next-state function. Produces the next register value and,
// for the flags, a new value plus a strobe saying whether the flag updates.
module usr_next_state
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  mode_t            i_mode,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_sin_l,
  input  logic             i_sin_r,
  output logic [WIDTH-1:0] o_q,
  output logic             o_sout,
  output logic             o_carry,
  output logic             o_sout_upd,
  output logic             o_carry_upd
);

  // Mode decode; the extra MSB on INC/DEC captures carry-out / borrow-out.
  always_comb begin
    o_q         = i_q;
    o_sout      = 1'b0;
    o_carry     = 1'b0;
    o_sout_upd  = 1'b0;
    o_carry_upd = 1'b0;
    case (i_mode)
      MODE_LOAD: begin
        o_q         = i_d;
        o_carry_upd = 1'b1;
      end
      MODE_SHL: begin
        o_q        = {i_q[WIDTH-2:0], i_sin_l};
        o_sout     = i_q[WIDTH-1];
        o_sout_upd = 1'b1;
      end
      MODE_SHR: begin
        o_q        = {i_sin_r, i_q[WIDTH-1:1]};
        o_sout     = i_q[0];
        o_sout_upd = 1'b1;
      end
      MODE_ROL: begin
        o_q        = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
        o_sout     = i_q[WIDTH-1];
        o_sout_upd = 1'b1;
      end
      MODE_ROR: begin
        o_q        = {i_q[0], i_q[WIDTH-1:1]};
        o_sout     = i_q[0];
        o_sout_upd = 1'b1;
      end
      MODE_INC: begin
        {o_carry, o_q} = {1'b0, i_q} + (WIDTH+1)'(1);
        o_carry_upd    = 1'b1;
      end
      MODE_DEC: begin
        {o_carry, o_q} = {1'b0, i_q} - (WIDTH+1)'(1);
        o_carry_upd    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/load/shift/rotate/inc/dec with serial-out,
// carry/borrow and zero flags. Owns the flops and the rst > en priority.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic               clk,
  input logic               rst,
  univ_shift_reg_if.slave   bus
);

  logic [WIDTH-1:0] r_q;
  logic             r_sout;
  logic             r_carry;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_sout_nxt;
  logic             w_carry_nxt;
  logic             w_sout_upd;
  logic             w_carry_upd;

  usr_next_state #(.WIDTH(WIDTH)) u_ns (
    .i_q         (r_q),
    .i_mode      (bus.mode),
    .i_d         (bus.d),
    .i_sin_l     (bus.sin_l),
    .i_sin_r     (bus.sin_r),
    .o_q         (w_q_nxt),
    .o_sout      (w_sout_nxt),
    .o_carry     (w_carry_nxt),
    .o_sout_upd  (w_sout_upd),
    .o_carry_upd (w_carry_upd)
  );

  // State update: reset wins, then enable gates every register and flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= RST_VAL;
      r_sout  <= 1'b0;
      r_carry <= 1'b0;
    end else if (bus.en) begin
      r_q <= w_q_nxt;
      if (w_sout_upd)  r_sout  <= w_sout_nxt;
      if (w_carry_upd) r_carry <= w_carry_nxt;
    end
  end

  assign bus.q     = r_q;
  assign bus.sout  = r_sout;
  assign bus.carry = r_carry;
  assign bus.zero  = ~|r_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench: three instances (W=8/RST 0, W=2/RST 1, W=16/RST 1) share
// one stimulus stream; an arithmetic reference model pushes expectations and
// a monitor pops and compares after every edge.
module tb_univ_shift_reg;
  import usr_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en;
  mode_t       mode;
  logic [15:0] d;
  logic        sin_l;
  logic        sin_r;

  univ_shift_reg_if #(.WIDTH(8))  if8  ();
  univ_shift_reg_if #(.WIDTH(2))  if2  ();
  univ_shift_reg_if #(.WIDTH(16)) if16 ();

  assign if8.en  = en;   assign if8.mode  = mode; assign if8.d  = d[7:0];
  assign if8.sin_l = sin_l;  assign if8.sin_r = sin_r;
  assign if2.en  = en;   assign if2.mode  = mode; assign if2.d  = d[1:0];
  assign if2.sin_l = sin_l;  assign if2.sin_r = sin_r;
  assign if16.en = en;   assign if16.mode = mode; assign if16.d = d;
  assign if16.sin_l = sin_l; assign if16.sin_r = sin_r;

  univ_shift_reg #(.WIDTH(8),  .RST_VAL(8'd0))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
  univ_shift_reg #(.WIDTH(2),  .RST_VAL(2'd1))  u_dut2  (.clk(clk), .rst(rst), .bus(if2));
  univ_shift_reg #(.WIDTH(16), .RST_VAL(16'd1)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

  typedef struct {
    int unsigned q;
    logic        sout;
    logic        carry;
    logic        zero;
  } exp_t;

  exp_t        sb [3][$];
  int unsigned mq [3];
  logic        ms [3];
  logic        mc [3];
  int          wd [3] = '{8, 2, 16};
  int unsigned rv [3] = '{0, 1, 1};
  int          vectors = 0;
  int          errors  = 0;

  // Reference model: registers viewed as integers modulo 2^W.
  function automatic void model_step(int k, logic r, logic e, mode_t m,
                                     logic [15:0] dd, logic sl, logic sr);
    int unsigned mm   = 32'd1 << wd[k];
    int unsigned half = mm / 2;
    int unsigned qq   = mq[k];
    if (r) begin
      mq[k] = rv[k]; ms[k] = 1'b0; mc[k] = 1'b0;
    end else if (e) begin
      case (m)
        MODE_LOAD: begin mq[k] = {16'b0, dd} % mm; mc[k] = 1'b0; end
        MODE_SHL:  begin ms[k] = (qq >= half); mq[k] = (qq * 2 + (sl ? 1 : 0)) % mm; end
        MODE_SHR:  begin ms[k] = (qq % 2 == 1); mq[k] = qq / 2 + (sr ? half : 0); end
        MODE_ROL:  begin ms[k] = (qq >= half); mq[k] = (qq * 2) % mm + ((qq >= half) ? 1 : 0); end
        MODE_ROR:  begin ms[k] = (qq % 2 == 1); mq[k] = qq / 2 + ((qq % 2 == 1) ? half : 0); end
        MODE_INC:  begin mc[k] = (qq + 1 == mm); mq[k] = (qq + 1) % mm; end
        MODE_DEC:  begin mc[k] = (qq == 0); mq[k] = (qq + mm - 1) % mm; end
        default: ;
      endcase
    end
    sb[k].push_back('{mq[k], ms[k], mc[k], mq[k] == 0});
  endfunction

  function automatic void cmp(int k, string nm, int unsigned eq, logic es, logic ec, logic ez);
    int unsigned aq;
    logic as_, ac, az;
    case (k)
      0:       begin aq = {24'b0, if8.q};  as_ = if8.sout;  ac = if8.carry;  az = if8.zero;  end
      1:       begin aq = {30'b0, if2.q};  as_ = if2.sout;  ac = if2.carry;  az = if2.zero;  end
      default: begin aq = {16'b0, if16.q}; as_ = if16.sout; ac = if16.carry; az = if16.zero; end
    endcase
    vectors++;
    if (aq !== eq || as_ !== es || ac !== ec || az !== ez) begin
      errors++;
      $display("FAIL %s W=%0d t=%0t got q=%0h sout=%b carry=%b zero=%b want q=%0h sout=%b carry=%b zero=%b",
               nm, wd[k], $time, aq, as_, ac, az, eq, es, ec, ez);
    end
  endfunction

  // Drive one cycle of stimulus on the falling edge and record expectations.
  task automatic step(logic r, logic e, mode_t m, logic [15:0] dd, logic sl, logic sr);
    @(negedge clk);
    rst = r; en = e; mode = m; d = dd; sin_l = sl; sin_r = sr;
    for (int k = 0; k < 3; k++) model_step(k, r, e, m, dd, sl, sr);
  endtask

  // Directed check of one instance against hand-derived constants.
  task automatic chk(int k, string nm, int unsigned eq, logic es, logic ec);
    @(posedge clk); #1;
    cmp(k, nm, eq, es, ec, eq == 0);
  endtask

  // Monitor: every edge, compare each instance with its next expectation.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        if (sb[k].size() > 0) begin
          ex = sb[k].pop_front();
          cmp(k, "scoreboard", ex.q, ex.sout, ex.carry, ex.zero);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; mode = MODE_HOLD; d = '0; sin_l = 1'b0; sin_r = 1'b0;

    step(1, 1, MODE_HOLD, 16'h0, 0, 0);  chk(0, "rst8",  8'h00, 0, 0);
    chk(1, "rst2_now", 1, 0, 0);
    repeat (3) step(0, 1, MODE_HOLD, 16'h0, 0, 0);
    chk(0, "hold8", 8'h00, 0, 0);
    chk(2, "hold16", 1, 0, 0);

    step(0, 1, MODE_LOAD, 16'h00AA, 0, 0); chk(0, "load_aa", 8'hAA, 0, 0);
    step(0, 1, MODE_SHL,  16'h0, 1, 0);    chk(0, "shl",     8'h55, 1, 0);
    step(0, 1, MODE_SHR,  16'h0, 0, 0);    chk(0, "shr",     8'h2A, 1, 0);
    step(0, 0, MODE_SHL,  16'hFF, 1, 1);
    step(0, 0, MODE_SHL,  16'hFF, 1, 1);   chk(0, "en_off",  8'h2A, 1, 0);

    step(0, 1, MODE_LOAD, 16'h0081, 0, 0);
    step(0, 1, MODE_ROL,  16'h0, 0, 0);    chk(0, "rol",     8'h03, 1, 0);
    step(0, 1, MODE_ROR,  16'h0, 0, 0);    chk(0, "ror1",    8'h81, 1, 0);
    step(0, 1, MODE_ROR,  16'h0, 0, 0);    chk(0, "ror2",    8'hC0, 1, 0);

    step(0, 1, MODE_LOAD, 16'h00FE, 0, 0);
    step(0, 1, MODE_INC,  16'h0, 0, 0);    chk(0, "inc_ff",  8'hFF, 1, 0);
    step(0, 1, MODE_INC,  16'h0, 0, 0);    chk(0, "inc_wrap",8'h00, 1, 1);
    step(0, 1, MODE_DEC,  16'h0, 0, 0);    chk(0, "dec_wrap",8'hFF, 1, 1);
    step(0, 1, MODE_DEC,  16'h0, 0, 0);    chk(0, "dec_fe",  8'hFE, 1, 0);

    step(0, 1, MODE_LOAD, 16'h00F0, 0, 0);
    step(0, 1, MODE_INC,  16'h0, 0, 0);
    step(0, 1, MODE_INC,  16'h0, 0, 0);    chk(0, "inc_f2",  8'hF2, 1, 0);
    step(1, 1, MODE_INC,  16'h0, 1, 1);    chk(0, "rst_mid", 8'h00, 0, 0);
    step(0, 1, MODE_INC,  16'h0, 0, 0);    chk(0, "resume",  8'h01, 0, 0);

    // Width-2 full count cycle from RST_VAL = 1.
    step(1, 1, MODE_DEC,  16'h0, 0, 0);    chk(1, "w2_rst",  1, 0, 0);
    step(0, 1, MODE_INC,  16'h0, 0, 0);    chk(1, "w2_i1",   2, 0, 0);
    step(0, 1, MODE_INC,  16'h0, 0, 0);    chk(1, "w2_i2",   3, 0, 0);
    step(0, 1, MODE_INC,  16'h0, 0, 0);    chk(1, "w2_wrap", 0, 0, 1);
    step(0, 1, MODE_INC,  16'h0, 0, 0);    chk(1, "w2_i4",   1, 0, 0);

    // Randomized traffic, occasional reset and frequent enable gaps.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 4) != 0),
           mode_t'($urandom_range(0, 7)), 16'($urandom),
           1'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised successor to the team's 8-bit D register.
- A WIDTH-bit register with a one-cycle mode-selected next-state function: hold, parallel load, logical shifts with serial inputs, rotates, and increment/decrement.
- Flags report serial shift-out, carry/borrow and zero.
- Used as the general-purpose storage, shift and count element in datapaths where a plain register is insufficient.

Parameters:
- WIDTH, 8, data width in bits; legal range is WIDTH >= 2.
- RST_VAL, 0, value loaded into q on reset; WIDTH bits wide.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  operation enable; when 0, all state holds.
- mode  in  3  operation select (encoding below).
- d  in  WIDTH  parallel load data.
- sin_l  in  1  serial input shifted into bit 0 on SHL.
- sin_r  in  1  serial input shifted into bit WIDTH-1 on SHR.
- q  out  WIDTH  register contents.
- sout  out  1  bit most recently shifted or rotated out.
- carry  out  1  carry from INC, or borrow from DEC.
- zero  out  1  high when q == 0.

Behaviour:
- Timing and reset
  - Single clock. All state updates on the rising edge of clk.
  - rst is sampled only at the edge and has priority over en and mode.
  - Reset values: q = RST_VAL, sout = 0, carry = 0.
  - zero is combinational from q. After reset, zero = (RST_VAL == 0).
- Latency and enable
  - Latency is 1 cycle: the result of the mode sampled at edge N is visible on q after edge N.
  - en = 0 holds q, sout and carry regardless of mode, d or the serial inputs.
- Mode encoding, applied when en = 1 (q' is the next value, old q is the pre-edge value):
  - 000 HOLD: q, sout and carry all unchanged.
  - 001 LOAD: q' = d; carry' = 0; sout unchanged.
  - 010 SHL: q' = {q[W-2:0], sin_l}; sout' = q[W-1]; carry unchanged.
  - 011 SHR: q' = {sin_r, q[W-1:1]}; sout' = q[0]; carry unchanged.
  - 100 ROL: q' = {q[W-2:0], q[W-1]}; sout' = q[W-1]; carry unchanged.
  - 101 ROR: q' = {q[0], q[W-1:1]}; sout' = q[0]; carry unchanged.
  - 110 INC: q' = q + 1 modulo 2^W; carry' = 1 only if q was all ones (wrap to 0), otherwise 0; sout unchanged.
  - 111 DEC: q' = q - 1 modulo 2^W; carry' = 1 only if q was 0 (wrap to all ones), otherwise 0; sout unchanged.
- Boundary conditions
  - Arithmetic is unsigned. Widths are exact; no sign extension anywhere.
  - Wrap-around is the normal modular result, flagged only by carry.
  - The serial inputs are ignored in every mode except their own shift direction.
  - Reset asserted mid-sequence, in any mode, forces the reset values at that edge. The next non-reset edge resumes from RST_VAL.
  - rst = 1 together with en = 1 and any mode: reset wins.
  - d changes while not in LOAD have no effect.

Decomposition:
- Shared package usr_pkg holds:
  - the mode encoding constants: MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_INC, MODE_DEC;
  - a 3-bit mode typedef.
- One natural combinational sub-module, usr_next_state:
  - inputs: q, mode, d, sin_l, sin_r;
  - outputs: next q, next sout, next carry, plus update strobes for sout and carry.
  - The top level owns the flops and the rst/en priority.

Test Plan (WIDTH = 8, RST_VAL = 0):
- rst = 1 for one edge, then rst = 0 with en = 1, mode = HOLD -> q = 0x00, zero = 1, sout = 0, carry = 0; values stable over 3 edges.
- LOAD d = 0xAA; SHL sin_l = 1 -> q = 0x55, sout = 1; SHR sin_r = 0 -> q = 0x2A, sout = 1; then en = 0 with mode = SHL for 2 edges -> q stays 0x2A.
- LOAD 0x81; ROL -> q = 0x03, sout = 1; ROR -> q = 0x81, sout = 1; ROR again -> q = 0xC0, sout = 1.
- LOAD 0xFE; INC -> q = 0xFF, carry = 0; INC -> q = 0x00, carry = 1, zero = 1; DEC -> q = 0xFF, carry = 1; DEC -> q = 0xFE, carry = 0.
- LOAD 0xF0 then INC for 2 edges (q = 0xF2); rst = 1 with en = 1, mode = INC on the next edge -> q = 0x00, carry = 0, sout = 0; after release, INC -> q = 0x01.
- Parameter sweep WIDTH = 2 and WIDTH = 16 with RST_VAL = 1: after reset q = 1, zero = 0; a full cycle of 2^WIDTH INC edges (WIDTH = 2) returns q to 1, with carry = 1 only on the wrap edge.
